rename_map: RTL and testbench
=============================

// Module: rename_map
// PURPOSE
//  Superscalar register alias table for the dispatch stage: W-wide, replacing the 1-wide ARF/ROB + tag tables.
//  Per source, returns whether the operand is speculative (in the ROB) and, if so, its producing ROB id.
//  Bypasses intra-group dependencies, clears mappings on retire, and flushes all speculative state on mispredict.
//  Sits between decode and the IIQ/LSQ dispatch muxes; ROB and ARF data reads stay outside this block.
// PARAMETERS
//  DISPATCH_WIDTH  2  rename slots per cycle (W); slot 0 is the oldest
//  RETIRE_WIDTH    1  retire clear ports per cycle (R); port 0 is the oldest
//  N_ARF          32  architectural registers; x0 is never renamed
//  ROB_ID_WIDTH    4  ROB tag width (`ROB_ID_WIDTH)
// PORTS
//  clk            in   1        clock
//  rst_aL         in   1        synchronous active-low reset
//  flush          in   1        branch/load mispredict: discard all speculative mappings
//  disp_valid     in   W        slot k renames this cycle; must be contiguous from slot 0 (thermometer)
//  disp_rs1       in   W*5      slot k source-1 ARF id
//  disp_rs2       in   W*5      slot k source-2 ARF id
//  disp_rd_valid  in   W        slot k writes a destination
//  disp_rd        in   W*5      slot k destination ARF id
//  disp_rob_id    in   W*RIW    ROB id allocated to slot k
//  src1_spec      out  W        1 = slot k rs1 comes from the ROB; 0 = from the ARF
//  src1_rob_id    out  W*RIW    producer tag for slot k rs1 (don't-care when src1_spec=0)
//  src2_spec      out  W        as src1_spec, for rs2
//  src2_rob_id    out  W*RIW    as src1_rob_id, for rs2
//  ret_valid      in   R        retire port p is active
//  ret_arf_id     in   R*5      destination ARF id of the retiring instruction
//  ret_rob_id     in   R*RIW    ROB id of the retiring instruction
//  spec_count     out  6        registered count of spec bits set (0..N_ARF-1)
// BEHAVIOUR
//  State
//   - spec[N_ARF] bits and tag[N_ARF] entries of RIW bits.
//   - Reset (rst_aL=0 at a clk edge): all spec=0, all tag=0, spec_count=0.
//   - Outputs are combinational; src*_spec=0 during reset.
//  Lookup (0-cycle, combinational)
//   - Source is x0 -> spec=0, rob_id=0.
//   - Else if an older slot j<k in this group has disp_valid[j] & disp_rd_valid[j] & disp_rd[j]==src & src!=x0:
//     spec=1, rob_id=disp_rob_id[j], using the youngest such j.
//   - Else the source reads spec[src] and tag[src] from state.
//  Rename write (next edge)
//   - Every valid slot with rd_valid and rd!=x0 sets spec[rd]=1 and tag[rd]=disp_rob_id.
//   - Same rd in two slots: the highest slot index wins.
//  Retire clear (next edge)
//   - Port p clears spec[ret_arf_id] only if tag[ret_arf_id]==ret_rob_id (register not renamed since).
//   - A same-cycle dispatch write to that register beats the clear: spec stays 1 and tag takes the new id.
//   - ret_arf_id==x0 is ignored.
//  Flush (next edge)
//   - Highest priority: all spec=0; dispatch writes and retire clears that cycle are dropped; tags are not cleared.
//   - Lookup outputs in the flush cycle still reflect the pre-flush state; the consumer discards them.
//   - Priority order: reset > flush > dispatch write > retire clear.
//  spec_count
//   - Registered popcount of the next-state spec vector; updates on the same edge as spec.
//   - Reads 0 the cycle after a flush.
//  No stalls inside the block: the caller gates disp_valid with the ROB/IIQ/LSQ handshake.
// STRUCTURE
//  global_defs.svh holds:
//   - arf_id_t (5b), rob_id_t (`ROB_ID_WIDTH).
//   - `DISPATCH_WIDTH, `RETIRE_WIDTH.
//  Sub-module rename_src_bypass:
//   - Combinational priority match of one source against older slots' rd.
//   - Instanced 2*W times; outputs hit and rob_id.
//  State uses reg_ per entry with per-bit enables built from the rename, retire and flush decodes.
// TESTING
//  1. Reset, then lookup rs1=5, rs2=0 in slot 0 -> src1_spec=0, src2_spec=0, spec_count=0.
//  2. Slot0 rd=3 (rob 2), slot1 rs1=3 -> slot1 src1_spec=1, rob_id=2 in the same cycle.
//     Next cycle, rs1=3 lookup -> spec=1, rob_id=2, and spec_count=1.
//  3. Slot0 and slot1 both write rd=7 (rob 4, rob 5) -> tag[7]=5.
//     Later retire (7, rob 4) -> spec[7] stays 1.
//     Then retire (7, rob 5) -> spec[7]=0.
//  4. Retire (3, rob 2) in the same cycle that slot0 renames rd=3 to rob 6 -> spec[3]=1, tag[3]=6.
//  5. Set spec on regs 1, 2, 9, then assert flush together with a slot0 rename of rd=4
//     -> next cycle all spec=0 (reg 4 included) and spec_count=0.
//  6. Rename rd=0 and retire x0 -> no state change; rs1=0 lookup -> spec=0.
//     Deassert rst_aL mid-stream -> every state bit and spec_count are 0 at the next edge.

Source files
------------

// File: rtl/rename_map_pkg.sv
// Shared widths, id types and helpers for the register alias table.
package rename_map_pkg;

  localparam int DISPATCH_WIDTH = 2;
  localparam int RETIRE_WIDTH   = 1;
  localparam int N_ARF          = 32;
  localparam int ARF_ID_WIDTH   = 5;
  localparam int ROB_ID_WIDTH   = 4;
  localparam int COUNT_WIDTH    = 6;

  typedef logic [ARF_ID_WIDTH-1:0] arf_id_t;
  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;

  // Number of set bits in a spec vector; 6 bits covers the full 0..32 range.
  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [N_ARF-1:0] v);
    logic [COUNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_ARF; i++) begin
      cnt = cnt + COUNT_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rename_src_bypass.sv
// Intra-group bypass for one source operand: finds the youngest older slot
// in the same dispatch group that writes this source register.
module rename_src_bypass
  import rename_map_pkg::*;
#(
  parameter int SLOT = 0
) (
  input  arf_id_t                        src,
  input  logic    [DISPATCH_WIDTH-1:0]   disp_valid,
  input  logic    [DISPATCH_WIDTH-1:0]   disp_rd_valid,
  input  arf_id_t [DISPATCH_WIDTH-1:0]   disp_rd,
  input  rob_id_t [DISPATCH_WIDTH-1:0]   disp_rob_id,
  output logic                           hit,
  output rob_id_t                        rob_id
);

  // Ascending scan so the youngest matching older slot overwrites earlier hits.
  always_comb begin
    hit    = 1'b0;
    rob_id = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      if (j < SLOT && disp_valid[j] && disp_rd_valid[j] &&
          disp_rd[j] == src && src != '0) begin
        hit    = 1'b1;
        rob_id = disp_rob_id[j];
      end
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register alias table: per-source speculative/ROB-id lookup with
// intra-group bypass, rename writes, tag-checked retire clears and flush.
module rename_map
  import rename_map_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_aL,
  input  logic                          flush,
  input  logic    [DISPATCH_WIDTH-1:0]  disp_valid,
  input  arf_id_t [DISPATCH_WIDTH-1:0]  disp_rs1,
  input  arf_id_t [DISPATCH_WIDTH-1:0]  disp_rs2,
  input  logic    [DISPATCH_WIDTH-1:0]  disp_rd_valid,
  input  arf_id_t [DISPATCH_WIDTH-1:0]  disp_rd,
  input  rob_id_t [DISPATCH_WIDTH-1:0]  disp_rob_id,
  output logic    [DISPATCH_WIDTH-1:0]  src1_spec,
  output rob_id_t [DISPATCH_WIDTH-1:0]  src1_rob_id,
  output logic    [DISPATCH_WIDTH-1:0]  src2_spec,
  output rob_id_t [DISPATCH_WIDTH-1:0]  src2_rob_id,
  input  logic    [RETIRE_WIDTH-1:0]    ret_valid,
  input  arf_id_t [RETIRE_WIDTH-1:0]    ret_arf_id,
  input  rob_id_t [RETIRE_WIDTH-1:0]    ret_rob_id,
  output logic    [COUNT_WIDTH-1:0]     spec_count
);

  logic    [N_ARF-1:0] spec_q;
  logic    [N_ARF-1:0] spec_nxt;
  logic    [N_ARF-1:0] spec_set;
  logic    [N_ARF-1:0] spec_clr;
  logic    [N_ARF-1:0] tag_we;
  rob_id_t             tag_q   [N_ARF];
  rob_id_t             tag_wd  [N_ARF];
  rob_id_t             tag_nxt [N_ARF];

  logic    [DISPATCH_WIDTH-1:0] b1_hit;
  logic    [DISPATCH_WIDTH-1:0] b2_hit;
  rob_id_t [DISPATCH_WIDTH-1:0] b1_rob;
  rob_id_t [DISPATCH_WIDTH-1:0] b2_rob;

  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_bypass
    rename_src_bypass #(.SLOT(k)) u_byp_rs1 (
      .src           (disp_rs1[k]),
      .disp_valid    (disp_valid),
      .disp_rd_valid (disp_rd_valid),
      .disp_rd       (disp_rd),
      .disp_rob_id   (disp_rob_id),
      .hit           (b1_hit[k]),
      .rob_id        (b1_rob[k])
    );
    rename_src_bypass #(.SLOT(k)) u_byp_rs2 (
      .src           (disp_rs2[k]),
      .disp_valid    (disp_valid),
      .disp_rd_valid (disp_rd_valid),
      .disp_rd       (disp_rd),
      .disp_rob_id   (disp_rob_id),
      .hit           (b2_hit[k]),
      .rob_id        (b2_rob[k])
    );
  end

  // Source lookup: x0 is never speculative, bypass beats table state, reset masks spec.
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      src1_spec[k]   = 1'b0;
      src1_rob_id[k] = '0;
      src2_spec[k]   = 1'b0;
      src2_rob_id[k] = '0;
      if (disp_rs1[k] != '0) begin
        if (b1_hit[k]) begin
          src1_spec[k]   = 1'b1;
          src1_rob_id[k] = b1_rob[k];
        end else begin
          src1_spec[k]   = spec_q[disp_rs1[k]];
          src1_rob_id[k] = tag_q[disp_rs1[k]];
        end
      end
      if (disp_rs2[k] != '0) begin
        if (b2_hit[k]) begin
          src2_spec[k]   = 1'b1;
          src2_rob_id[k] = b2_rob[k];
        end else begin
          src2_spec[k]   = spec_q[disp_rs2[k]];
          src2_rob_id[k] = tag_q[disp_rs2[k]];
        end
      end
      if (!rst_aL) begin
        src1_spec[k] = 1'b0;
        src2_spec[k] = 1'b0;
      end
    end
  end

  // Per-entry set/clear/tag-write enables from the rename and retire ports.
  always_comb begin
    spec_set = '0;
    spec_clr = '0;
    tag_we   = '0;
    for (int i = 0; i < N_ARF; i++) begin
      tag_wd[i] = tag_q[i];
    end
    // A later slot overwrites an earlier one, so the highest slot wins on a shared rd.
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (disp_valid[k] && disp_rd_valid[k] && disp_rd[k] != '0) begin
        spec_set[disp_rd[k]] = 1'b1;
        tag_we[disp_rd[k]]   = 1'b1;
        tag_wd[disp_rd[k]]   = disp_rob_id[k];
      end
    end
    // Clear only when the register still maps to the retiring instruction.
    for (int p = 0; p < RETIRE_WIDTH; p++) begin
      if (ret_valid[p] && ret_arf_id[p] != '0 &&
          tag_q[ret_arf_id[p]] == ret_rob_id[p]) begin
        spec_clr[ret_arf_id[p]] = 1'b1;
      end
    end
  end

  // Next state: flush wipes spec and drops writes; a rename set overrides a retire clear.
  always_comb begin
    if (flush) begin
      spec_nxt = '0;
    end else begin
      spec_nxt = (spec_q & ~spec_clr) | spec_set;
    end
    for (int i = 0; i < N_ARF; i++) begin
      tag_nxt[i] = (!flush && tag_we[i]) ? tag_wd[i] : tag_q[i];
    end
  end

  // State registers and the popcount of the next spec vector.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      spec_q     <= '0;
      spec_count <= '0;
      for (int i = 0; i < N_ARF; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      spec_q     <= spec_nxt;
      spec_count <= popcount(spec_nxt);
      for (int i = 0; i < N_ARF; i++) begin
        tag_q[i] <= tag_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Randomized bench for rename_map against an array-based alias-table model.
module tb_rename_map;
  import rename_map_pkg::*;

  localparam int W = DISPATCH_WIDTH;
  localparam int R = RETIRE_WIDTH;

  logic                    clk;
  logic                    rst_aL;
  logic                    flush;
  logic    [W-1:0]         disp_valid;
  arf_id_t [W-1:0]         disp_rs1;
  arf_id_t [W-1:0]         disp_rs2;
  logic    [W-1:0]         disp_rd_valid;
  arf_id_t [W-1:0]         disp_rd;
  rob_id_t [W-1:0]         disp_rob_id;
  logic    [W-1:0]         src1_spec;
  rob_id_t [W-1:0]         src1_rob_id;
  logic    [W-1:0]         src2_spec;
  rob_id_t [W-1:0]         src2_rob_id;
  logic    [R-1:0]         ret_valid;
  arf_id_t [R-1:0]         ret_arf_id;
  rob_id_t [R-1:0]         ret_rob_id;
  logic    [COUNT_WIDTH-1:0] spec_count;

  rename_map dut (
    .clk           (clk),
    .rst_aL        (rst_aL),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_rs1      (disp_rs1),
    .disp_rs2      (disp_rs2),
    .disp_rd_valid (disp_rd_valid),
    .disp_rd       (disp_rd),
    .disp_rob_id   (disp_rob_id),
    .src1_spec     (src1_spec),
    .src1_rob_id   (src1_rob_id),
    .src2_spec     (src2_spec),
    .src2_rob_id   (src2_rob_id),
    .ret_valid     (ret_valid),
    .ret_arf_id    (ret_arf_id),
    .ret_rob_id    (ret_rob_id),
    .spec_count    (spec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit      spec_m [N_ARF];
  rob_id_t tag_m  [N_ARF];
  int      cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model lookup straight from the rules: x0, then youngest older writer, then table.
  function automatic void mlook(input int k, input arf_id_t src, output bit sp, output rob_id_t id);
    sp = 1'b0;
    id = '0;
    if (src == 0) return;
    sp = spec_m[src];
    id = tag_m[src];
    for (int j = 0; j < k; j++) begin
      if (disp_valid[j] && disp_rd_valid[j] && disp_rd[j] == src) begin
        sp = 1'b1;
        id = disp_rob_id[j];
      end
    end
    if (!rst_aL) sp = 1'b0;
  endfunction

  task automatic clear_in();
    flush         = 1'b0;
    disp_valid    = '0;
    disp_rs1      = '0;
    disp_rs2      = '0;
    disp_rd_valid = '0;
    disp_rd       = '0;
    disp_rob_id   = '0;
    ret_valid     = '0;
    ret_arf_id    = '0;
    ret_rob_id    = '0;
  endtask

  // One clock: check lookups mid-cycle, advance the model, check spec_count after the edge.
  task automatic cycle();
    bit      sp;
    rob_id_t id;
    bit      ns [N_ARF];
    rob_id_t nt [N_ARF];
    int      c;
    @(negedge clk);
    for (int k = 0; k < W; k++) begin
      mlook(k, disp_rs1[k], sp, id);
      chk("src1_spec", 32'(src1_spec[k]), 32'(sp));
      if (sp || disp_rs1[k] == 0) chk("src1_rob_id", 32'(src1_rob_id[k]), 32'(id));
      mlook(k, disp_rs2[k], sp, id);
      chk("src2_spec", 32'(src2_spec[k]), 32'(sp));
      if (sp || disp_rs2[k] == 0) chk("src2_rob_id", 32'(src2_rob_id[k]), 32'(id));
    end
    for (int i = 0; i < N_ARF; i++) begin
      ns[i] = spec_m[i];
      nt[i] = tag_m[i];
    end
    for (int p = 0; p < R; p++) begin
      if (ret_valid[p] && ret_arf_id[p] != 0 && tag_m[ret_arf_id[p]] == ret_rob_id[p])
        ns[ret_arf_id[p]] = 1'b0;
    end
    for (int k = 0; k < W; k++) begin
      if (disp_valid[k] && disp_rd_valid[k] && disp_rd[k] != 0) begin
        ns[disp_rd[k]] = 1'b1;
        nt[disp_rd[k]] = disp_rob_id[k];
      end
    end
    if (flush) begin
      for (int i = 0; i < N_ARF; i++) begin
        ns[i] = 1'b0;
        nt[i] = tag_m[i];
      end
    end
    if (!rst_aL) begin
      for (int i = 0; i < N_ARF; i++) begin
        ns[i] = 1'b0;
        nt[i] = '0;
      end
    end
    c = 0;
    for (int i = 0; i < N_ARF; i++) c += int'(ns[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_ARF; i++) begin
      spec_m[i] = ns[i];
      tag_m[i]  = nt[i];
    end
    cnt_m = c;
    chk("spec_count", 32'(spec_count), 32'(cnt_m));
  endtask

  task automatic rename0(input arf_id_t rd, input rob_id_t rob);
    disp_valid[0]    = 1'b1;
    disp_rd_valid[0] = 1'b1;
    disp_rd[0]       = rd;
    disp_rob_id[0]   = rob;
  endtask

  initial begin
    int n;
    int a;
    for (int i = 0; i < N_ARF; i++) begin
      spec_m[i] = 1'b0;
      tag_m[i]  = '0;
    end
    cnt_m  = 0;
    rst_aL = 1'b0;
    clear_in();
    cycle();
    cycle();
    rst_aL = 1'b1;

    // Reset state lookups
    disp_valid = 2'b01;
    disp_rs1[0] = 5'd5;
    disp_rs2[0] = 5'd0;
    #1;
    chk("t1_rs1_spec", 32'(src1_spec[0]), 32'd0);
    chk("t1_rs2_spec", 32'(src2_spec[0]), 32'd0);
    chk("t1_rs2_id", 32'(src2_rob_id[0]), 32'd0);
    chk("t1_cnt", 32'(spec_count), 32'd0);
    cycle();

    // Intra-group bypass, then table hit
    clear_in();
    rename0(5'd3, 4'd2);
    disp_valid  = 2'b11;
    disp_rs1[1] = 5'd3;
    #1;
    chk("t2_byp_spec", 32'(src1_spec[1]), 32'd1);
    chk("t2_byp_id", 32'(src1_rob_id[1]), 32'd2);
    cycle();
    clear_in();
    disp_valid  = 2'b01;
    disp_rs1[0] = 5'd3;
    #1;
    chk("t2_tbl_spec", 32'(src1_spec[0]), 32'd1);
    chk("t2_tbl_id", 32'(src1_rob_id[0]), 32'd2);
    chk("t2_cnt", 32'(spec_count), 32'd1);
    cycle();

    // Same rd in both slots: highest slot wins; stale retire does not clear
    clear_in();
    disp_valid    = 2'b11;
    disp_rd_valid = 2'b11;
    disp_rd[0] = 5'd7;  disp_rob_id[0] = 4'd4;
    disp_rd[1] = 5'd7;  disp_rob_id[1] = 4'd5;
    cycle();
    clear_in();
    ret_valid[0] = 1'b1; ret_arf_id[0] = 5'd7; ret_rob_id[0] = 4'd4;
    cycle();
    clear_in();
    disp_valid = 2'b01; disp_rs1[0] = 5'd7;
    #1;
    chk("t3_stale_spec", 32'(src1_spec[0]), 32'd1);
    chk("t3_tag", 32'(src1_rob_id[0]), 32'd5);
    ret_valid[0] = 1'b1; ret_arf_id[0] = 5'd7; ret_rob_id[0] = 4'd5;
    cycle();
    clear_in();
    disp_valid = 2'b01; disp_rs1[0] = 5'd7;
    #1;
    chk("t3_clear_spec", 32'(src1_spec[0]), 32'd0);
    cycle();

    // Rename beats a same-cycle retire clear
    clear_in();
    rename0(5'd3, 4'd6);
    ret_valid[0] = 1'b1; ret_arf_id[0] = 5'd3; ret_rob_id[0] = 4'd2;
    cycle();
    clear_in();
    disp_valid = 2'b01; disp_rs1[0] = 5'd3;
    #1;
    chk("t4_spec", 32'(src1_spec[0]), 32'd1);
    chk("t4_tag", 32'(src1_rob_id[0]), 32'd6);
    cycle();

    // Flush beats a same-cycle rename
    clear_in();
    disp_valid = 2'b11; disp_rd_valid = 2'b11;
    disp_rd[0] = 5'd1; disp_rob_id[0] = 4'd1;
    disp_rd[1] = 5'd2; disp_rob_id[1] = 4'd2;
    cycle();
    clear_in();
    rename0(5'd9, 4'd3);
    cycle();
    clear_in();
    rename0(5'd4, 4'd7);
    flush = 1'b1;
    cycle();
    clear_in();
    chk("t5_cnt", 32'(spec_count), 32'd0);
    disp_valid = 2'b11;
    disp_rs1[0] = 5'd4; disp_rs2[0] = 5'd9;
    disp_rs1[1] = 5'd1; disp_rs2[1] = 5'd2;
    #1;
    chk("t5_r4", 32'(src1_spec[0]), 32'd0);
    chk("t5_r9", 32'(src2_spec[0]), 32'd0);
    chk("t5_r1", 32'(src1_spec[1]), 32'd0);
    chk("t5_r2", 32'(src2_spec[1]), 32'd0);
    cycle();

    // x0 rename/retire are ignored; reset mid-stream clears everything
    clear_in();
    rename0(5'd6, 4'd1);
    cycle();
    clear_in();
    rename0(5'd0, 4'd9);
    ret_valid[0] = 1'b1; ret_arf_id[0] = 5'd0; ret_rob_id[0] = 4'd0;
    cycle();
    clear_in();
    chk("t6_x0_cnt", 32'(spec_count), 32'd1);
    disp_valid = 2'b01; disp_rs1[0] = 5'd0;
    #1;
    chk("t6_x0_spec", 32'(src1_spec[0]), 32'd0);
    rst_aL = 1'b0;
    cycle();
    rst_aL = 1'b1;
    clear_in();
    chk("t6_rst_cnt", 32'(spec_count), 32'd0);
    disp_valid = 2'b01; disp_rs1[0] = 5'd6;
    #1;
    chk("t6_rst_spec", 32'(src1_spec[0]), 32'd0);
    cycle();

    // Randomized traffic, registers biased low to force collisions
    for (int t = 0; t < 3000; t++) begin
      clear_in();
      n = $urandom_range(0, 2);
      disp_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      for (int k = 0; k < W; k++) begin
        disp_rs1[k]      = 5'($urandom_range(0, 7));
        disp_rs2[k]      = 5'($urandom_range(0, 7));
        disp_rd_valid[k] = 1'($urandom_range(0, 1));
        disp_rd[k]       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                       : 5'($urandom_range(0, 7));
        disp_rob_id[k]   = 4'($urandom);
      end
      ret_valid[0]  = 1'($urandom_range(0, 1));
      a             = $urandom_range(0, 7);
      ret_arf_id[0] = 5'(a);
      ret_rob_id[0] = ($urandom_range(0, 3) != 0) ? tag_m[a] : 4'($urandom);
      flush         = ($urandom_range(0, 31) == 0);
      rst_aL        = ($urandom_range(0, 255) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
